// File: rtl/imem_dump_reader_pkg.sv
// Shared constants for the instruction-memory dump reader: FSM encoding and
// the default data/address widths common to the memory, loader and reader.
package imem_dump_reader_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/imem_dump_chksum.sv
// DW-bit running sum; clr wins over en, both take effect on the next edge.
// No handshake: the owner pulses en once per word it wants summed.
module imem_dump_chksum #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/imem_dump_reader.sv
// Streams count words from base through a valid/ready port, summing them; first word
// 2 edges after start, one word per cycle while dout_ready holds, dout frozen when stalled.
module imem_dump_reader
  import imem_dump_reader_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] count,
  input  logic [AW-1:0] maxmem,
  output logic [AW-1:0] mar,
  input  logic [DW-1:0] memout,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [DW-1:0] checksum
);

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] remaining;

  logic slot_free;
  logic rem_nz;
  logic in_range;
  logic start_acc;
  logic load;

  assign slot_free = !dout_valid || dout_ready;
  assign rem_nz    = (remaining != '0);
  assign in_range  = (addr <= maxmem);
  assign start_acc = (state == ST_IDLE) && start;
  assign load      = (state == ST_RUN) && rem_nz && in_range && slot_free;

  // The memory port is only ours while a run is walking addresses.
  assign mar = (state == ST_RUN) ? addr : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      addr       <= '0;
      remaining  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr      <= base;
            remaining <= count;
            error     <= 1'b0;
            busy      <= 1'b1;
            if (count == '0) begin
              state <= ST_FIN;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Out-of-range abort drops any unaccepted word in dout.
          if (rem_nz && !in_range) begin
            error      <= 1'b1;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else if (load) begin
            dout       <= memout;
            dout_valid <= 1'b1;
            addr       <= addr + 1'b1;
            remaining  <= remaining - 1'b1;
          end else if (!rem_nz && slot_free) begin
            dout_valid <= 1'b0;
            done       <= 1'b1;
            state      <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  imem_dump_chksum #(
    .DW(DW)
  ) u_chksum (
    .clk  (clk),
    .rst_n(reset),
    .clr  (start_acc),
    .en   (load),
    .din  (memout),
    .sum  (checksum)
  );

endmodule

// File: tb/tb_imem_dump_reader.sv
// Bench for imem_dump_reader: scoreboard of expected words per run plus
// hand-computed literal checks on latency, checksum, error and reset.
module tb_imem_dump_reader;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam logic [AW-1:0] MAXMEM = 16'd4095;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] count;
  logic [AW-1:0] maxmem;
  logic [AW-1:0] mar;
  logic [DW-1:0] memout;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] checksum;

  always #5 clk = ~clk;

  imem_dump_reader #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .count     (count),
    .maxmem    (maxmem),
    .mar       (mar),
    .memout    (memout),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum)
  );

  logic [DW-1:0] mem [0:4095];

  always_comb begin
    memout = 16'hDEAD;
    if (mar < 16'd4096) memout = mem[mar[11:0]];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected word stream, sum and error for the current run.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_sum;
  logic          exp_err;
  logic          mon = 1'b0;
  int            done_seen;
  logic          stall_prev;
  logic [DW-1:0] prev_dout;

  always @(negedge clk) begin
    if (mon) begin
      if (dout_valid && exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_word got=%h want=none at %0t", dout, $time);
      end else if (dout_valid && dout_ready) begin
        chk("stream_word", {16'h0, dout}, {16'h0, exp_q.pop_front()});
      end
      if (stall_prev && !error) begin
        chk("stall_valid", {31'h0, dout_valid}, 32'h1);
        chk("stall_data", {16'h0, dout}, {16'h0, prev_dout});
      end
      stall_prev = dout_valid && !dout_ready;
      prev_dout  = dout;
      if (done) done_seen++;
    end
  end

  task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] c);
    logic [AW-1:0] a;
    exp_q.delete();
    exp_sum = '0;
    exp_err = 1'b0;
    for (int i = 0; i < int'(c); i++) begin
      a = b + AW'(i);
      if (a > MAXMEM) begin
        exp_err = 1'b1;
        break;
      end
      exp_q.push_back(mem[a[11:0]]);
      exp_sum = exp_sum + mem[a[11:0]];
    end
    done_seen  = 0;
    stall_prev = 1'b0;
    mon        = 1'b1;
    @(posedge clk); #1;
    base  = b;
    count = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=busy want=idle", tag);
    end
    @(negedge clk);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_checksum"}, {16'h0, checksum}, {16'h0, exp_sum});
    chk({tag, "_error"}, {31'h0, error}, {31'h0, exp_err});
    chk({tag, "_done_count"}, done_seen, exp_err ? 0 : 1);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = DW'(i) ^ 16'h5A5A;
    mem[0]    = 16'hB010;
    mem[1]    = 16'hEA00;
    mem[2]    = 16'hB000;
    mem[4094] = 16'h1234;
    mem[4095] = 16'h0F0F;

    reset      = 1'b0;
    start      = 1'b0;
    base       = '0;
    count      = '0;
    maxmem     = MAXMEM;
    dout_ready = 1'b1;
    #2;
    chk("rst_outputs", {mar, dout, dout_valid, busy, done, error, checksum}, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic run: literal latency and stream expectations.
    start_run(16'd0, 16'd3);
    @(negedge clk);
    chk("t1_first_gap_valid", {31'h0, dout_valid}, 32'h0);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("t1_w0", {15'h0, dout_valid, dout}, {15'h0, 1'b1, 16'hB010});
    @(negedge clk);
    chk("t1_w1", {15'h0, dout_valid, dout}, {15'h0, 1'b1, 16'hEA00});
    @(negedge clk);
    chk("t1_w2", {15'h0, dout_valid, dout}, {15'h0, 1'b1, 16'hB000});
    @(negedge clk);
    chk("t1_done", {30'h0, done, dout_valid}, 32'h2);
    chk("t1_sum", {16'h0, checksum}, 32'h4A10);
    @(negedge clk);
    chk("t1_done_clear", {30'h0, done, busy}, 32'h0);
    wait_end("t1");

    // Stall after the first word.
    dout_ready = 1'b0;
    start_run(16'd0, 16'd3);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    chk("t2_stall_hold", {15'h0, dout_valid, dout}, {15'h0, 1'b1, 16'hB010});
    #1;
    dout_ready = 1'b1;
    wait_end("t2");
    chk("t2_sum_lit", {16'h0, checksum}, 32'h4A10);

    // Zero-length run.
    start_run(16'd0, 16'd0);
    @(negedge clk);
    chk("t3_done", {30'h0, done, dout_valid}, 32'h2);
    @(negedge clk);
    chk("t3_after", {29'h0, done, busy, dout_valid}, 32'h0);
    wait_end("t3");

    // Run off the end of memory.
    start_run(16'd4094, 16'd4);
    wait_end("t4");
    chk("t4_err_lit", {30'h0, error, busy}, 32'h2);
    chk("t4_sum_lit", {16'h0, checksum}, 32'h2143);
    start_run(16'd2, 16'd1);
    @(negedge clk);
    chk("t4_err_cleared", {31'h0, error}, 32'h0);
    wait_end("t4b");

    // Asynchronous reset after one accepted word.
    start_run(16'd0, 16'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon = 1'b0;
    exp_q.delete();
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_outputs", {mar, dout, dout_valid, busy, done, error, checksum}, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_idle", {mar, 15'h0, busy}, 32'h0);
    start_run(16'd1, 16'd2);
    wait_end("t5");
    chk("t5_sum_lit", {16'h0, checksum}, 32'h9A00);

    // start while busy must not disturb the run.
    start_run(16'd0, 16'd3);
    @(posedge clk); #1;
    base  = 16'd4094;
    count = 16'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_end("t6");
    chk("t6_sum_lit", {16'h0, checksum}, 32'h4A10);

    mon = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
